// File: rtl/mcpu_alu_seq.sv
// Registered MCPU ALU with start/busy/done handshake; MUL multi-cycle when MCPU_ALU_MUL_EN is defined.
// Latency: 1 cycle for single-cycle ops, WORD_SIZE+1 cycles for MUL.
// Backpressure: start is ignored while busy=1, with no queueing; a start in the done cycle is accepted.
module mcpu_alu_seq #(
    parameter int CMD_SIZE  = 3,
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    output logic [WORD_SIZE-1:0] out,
    output logic                 OVERFLOW,
    output logic                 ZERO,
    output logic                 busy,
    output logic                 done
);

    localparam int W = WORD_SIZE;

    logic [2:0]   op;
    logic         accept;
    logic [W-1:0] res;
    logic         res_ovf;

    assign op     = opcode[2:0];
    assign accept = start & ~busy;

    // Single-cycle datapath works straight off the inputs sampled at the accept edge.
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        case (op)
            3'd0: res = r1 & r2;
            3'd1: res = r1 | r2;
            3'd2: res = r1 ^ r2;
            3'd3: begin
                res     = r1 + r2;
                res_ovf = (r1[W-1] == r2[W-1]) && (res[W-1] != r1[W-1]);
            end
            3'd4: begin
                res     = r1 - r2;
                res_ovf = (r1[W-1] != r2[W-1]) && (res[W-1] != r1[W-1]);
            end
            3'd6: begin
                res     = {r1[W-2:0], 1'b0};
                res_ovf = r1[W-1];
            end
            3'd7: res = {1'b0, r1[W-1:1]};
            default: begin
                res     = '0;
                res_ovf = 1'b0;
            end
        endcase
    end

`ifdef MCPU_ALU_MUL_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;
    localparam int CW = $clog2(WORD_SIZE);

    logic [0:0]     state;
    logic [W-1:0]   mcand;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_nxt;
    logic [W:0]     psum;
    logic [CW-1:0]  cnt;

    assign busy = (state == MUL);

    // Shift-add step: multiplier sits in the low half and drains out as the product shifts right.
    always_comb begin
        psum     = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mcand : {W{1'b0}})};
        prod_nxt = {psum, prod[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out      <= '0;
            OVERFLOW <= 1'b0;
            ZERO     <= 1'b1;
            done     <= 1'b0;
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == 3'd5) begin
                            state <= MUL;
                            mcand <= r1;
                            prod  <= {{W{1'b0}}, r2};
                            cnt   <= '0;
                        end else begin
                            out      <= res;
                            OVERFLOW <= res_ovf;
                            ZERO     <= ~|res;
                            done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + CW'(1);
                    // The final iteration's product is written straight to the result registers.
                    if (cnt == CW'(W - 1)) begin
                        out      <= prod_nxt[W-1:0];
                        OVERFLOW <= |prod_nxt[2*W-1:W];
                        ZERO     <= ~|prod_nxt[W-1:0];
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            OVERFLOW <= 1'b0;
            ZERO     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                out      <= res;
                OVERFLOW <= res_ovf;
                ZERO     <= ~|res;
                done     <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mcpu_alu_seq.sv
// Directed self-checking bench for mcpu_alu_seq; MUL cases run only when MCPU_ALU_MUL_EN is defined.
module tb_mcpu_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] opcode;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] out;
    logic       OVERFLOW;
    logic       ZERO;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    mcpu_alu_seq #(.CMD_SIZE(3), .WORD_SIZE(8)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .r1(r1), .r2(r2), .out(out), .OVERFLOW(OVERFLOW), .ZERO(ZERO),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request from a negedge, returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode = op; r1 = a; r2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic single(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] e_out, input logic e_ovf);
        issue(op, a, b);
        check({tag, ".done"}, done, 1);
        check({tag, ".out"}, out, e_out);
        check({tag, ".ovf"}, OVERFLOW, e_ovf);
        check({tag, ".zero"}, ZERO, (e_out == 8'h00));
    endtask

`ifdef MCPU_ALU_MUL_EN
    // Runs a MUL; optionally pulses an ADD start mid-busy. Reports latency, busy cycles and extra dones.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit pulse,
                           output int lat, output int bcnt, output int extra);
        lat = 0; bcnt = 0; extra = 0;
        issue(3'd5, a, b);
        for (int k = 1; k <= 20; k++) begin
            if (pulse && k == 3) begin opcode = 3'd3; r1 = 8'h01; r2 = 8'h01; start = 1'b1; end
            if (pulse && k == 4) start = 1'b0;
            if (done) begin lat = k; break; end
            if (busy) bcnt++;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
    endtask
`endif

    initial begin
        int lat, bcnt, extra, nd;
        reset = 1'b1; start = 1'b0; opcode = '0; r1 = '0; r2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst.out", out, 8'h00);
        check("rst.ovf", OVERFLOW, 0);
        check("rst.zero", ZERO, 1);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);

        single("add7f", 3'd3, 8'h7F, 8'h01, 8'h80, 1'b1);
        @(negedge clk);
        check("add7f.done_drop", done, 0);
        single("sub55", 3'd4, 8'h05, 8'h05, 8'h00, 1'b0);
        single("sub80", 3'd4, 8'h80, 8'h01, 8'h7F, 1'b1);
        single("and", 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        single("or", 3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0);
        single("xor", 3'd2, 8'hF0, 8'h3C, 8'hCC, 1'b0);
        single("shl81", 3'd6, 8'h81, 8'h00, 8'h02, 1'b1);
        single("shr81", 3'd7, 8'h81, 8'h00, 8'h40, 1'b0);

        // Result must hold with start low, even as the operands change.
        r1 = 8'hAA; opcode = 3'd3;
        repeat (3) @(negedge clk);
        check("hold.out", out, 8'h40);
        check("hold.done", done, 0);

        // Back-to-back: start stays high through the done cycle and is accepted again.
        opcode = 3'd3; r1 = 8'h02; r2 = 8'h03; start = 1'b1;
        @(negedge clk);
        check("b2b1.done", done, 1);
        check("b2b1.out", out, 8'h05);
        opcode = 3'd2; r1 = 8'hFF; r2 = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        check("b2b2.done", done, 1);
        check("b2b2.out", out, 8'hF0);
        @(negedge clk);

`ifdef MCPU_ALU_MUL_EN
        run_mul(8'h10, 8'h10, 1'b0, lat, bcnt, extra);
        check("mul10.latency", lat, 9);
        check("mul10.busy_cycles", bcnt, 8);
        check("mul10.out", out, 8'h00);
        check("mul10.ovf", OVERFLOW, 1);
        check("mul10.zero", ZERO, 1);
        check("mul10.extra_done", extra, 0);

        run_mul(8'h0C, 8'h0A, 1'b1, lat, bcnt, extra);
        check("mul0c.latency", lat, 9);
        check("mul0c.out", out, 8'h78);
        check("mul0c.ovf", OVERFLOW, 0);
        check("mul0c.zero", ZERO, 0);
        check("mul0c.ignored_start", extra, 0);
        check("mul0c.out_after", out, 8'h78);

        // Reset at cycle 4 of a multiply aborts it without a done.
        issue(3'd5, 8'h0C, 8'h0A);
        repeat (3) @(negedge clk);
        check("abort.busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`else
        // Opcode 5 without the multiplier: single-cycle, result zero.
        single("op5", 3'd5, 8'h12, 8'h34, 8'h00, 1'b0);
        check("op5.busy", busy, 0);
        single("pre_rst", 3'd7, 8'h81, 8'h00, 8'h40, 1'b0);
        // Reset wins over a simultaneous start.
        opcode = 3'd3; r1 = 8'h11; r2 = 8'h22; start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
`endif
        check("abort.busy", busy, 0);
        check("abort.out", out, 8'h00);
        check("abort.zero", ZERO, 1);
        check("abort.done", done, 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort.no_late_done", nd, 0);
        single("add23", 3'd3, 8'h02, 8'h03, 8'h05, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
